// File: rtl/board_pkg.sv
// Shared cell encodings and board defaults for the board-memory responder.
package board_pkg;

    localparam int unsigned BOARD_WIDTH = 6;

    localparam logic [1:0] CELL_WATER = 2'b00;
    localparam logic [1:0] CELL_BOAT  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b10;
    localparam logic [1:0] CELL_MISS  = 2'b11;

    typedef enum logic [0:0] {StClear, StIdle} clr_state_t;

endpackage

// File: rtl/board_clear_seq.sv
// Clear engine: walks every cell index once, one per cycle, while busy is high.
module board_clear_seq
    import board_pkg::*;
#(
    parameter int unsigned CELLS = 36,
    parameter int unsigned IW    = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr_start,
    output logic          clr_we,
    output logic [IW-1:0] clr_idx,
    output logic          busy
);

    clr_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StClear;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StClear: begin
                if (clr_start) begin
                    idx_d = '0;
                end else if (idx_q == IW'(CELLS - 1)) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    assign busy    = (state_q == StClear);
    assign clr_we  = busy;
    assign clr_idx = idx_q;

endmodule

// File: rtl/board_mem.sv
// Board cell store: one-cycle request responder, clear engine, boat counter and display port.
module board_mem
    import board_pkg::*;
#(
    parameter int unsigned WIDTH = BOARD_WIDTH,
    parameter int unsigned AW    = 3,
    parameter int unsigned CW    = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] mem_addr_x,
    input  logic [AW-1:0] mem_addr_y,
    input  logic [1:0]    mem_wr_data,
    input  logic          mem_wr_en,
    input  logic          mem_in_valid,
    output logic [1:0]    mem_rd_data,
    output logic          mem_ready,
    output logic          mem_err,
    input  logic          clr_start,
    output logic          busy,
    input  logic [AW-1:0] disp_x,
    input  logic [AW-1:0] disp_y,
    output logic [1:0]    disp_data,
    output logic [CW-1:0] boat_cnt,
    output logic          all_sunk
);

    localparam int unsigned CELLS = WIDTH * WIDTH;
    localparam int unsigned IW    = $clog2(CELLS);

    logic [1:0]    cells [CELLS];
    logic          clr_we;
    logic [IW-1:0] clr_idx;

    board_clear_seq #(
        .CELLS (CELLS),
        .IW    (IW)
    ) u_clear_seq (
        .clk       (clk),
        .rstn      (rstn),
        .clr_start (clr_start),
        .clr_we    (clr_we),
        .clr_idx   (clr_idx),
        .busy      (busy)
    );

    logic          accept, req_in_range, req_write, disp_in_range;
    logic [IW-1:0] req_idx, disp_idx;
    logic [1:0]    old_cell, disp_cell;

    assign accept        = mem_in_valid && !busy && !clr_start;
    assign req_in_range  = (32'(mem_addr_x) < WIDTH) && (32'(mem_addr_y) < WIDTH);
    assign req_idx       = IW'(32'(mem_addr_y) * WIDTH + 32'(mem_addr_x));
    assign req_write     = accept && req_in_range && mem_wr_en;
    assign old_cell      = req_in_range ? cells[req_idx] : CELL_WATER;
    assign disp_in_range = (32'(disp_x) < WIDTH) && (32'(disp_y) < WIDTH);
    assign disp_idx      = IW'(32'(disp_y) * WIDTH + 32'(disp_x));
    assign disp_cell     = (disp_in_range && !busy) ? cells[disp_idx] : CELL_WATER;

    // No reset on the array; the clear engine initialises it after every reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            cells[clr_idx] <= CELL_WATER;
        end else if (req_write) begin
            cells[req_idx] <= mem_wr_data;
        end
    end

    logic [1:0]    rd_d;
    logic [CW-1:0] cnt_d;

    always_comb begin
        rd_d  = mem_rd_data;
        cnt_d = boat_cnt;
        if (accept) begin
            rd_d = old_cell;
        end
        if (clr_start) begin
            cnt_d = '0;
        end else if (req_write) begin
            if (old_cell != CELL_BOAT && mem_wr_data == CELL_BOAT &&
                boat_cnt != CW'(CELLS)) begin
                cnt_d = boat_cnt + 1'b1;
            end else if (old_cell == CELL_BOAT && mem_wr_data != CELL_BOAT &&
                         boat_cnt != '0) begin
                cnt_d = boat_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_ready   <= 1'b0;
            mem_rd_data <= CELL_WATER;
            mem_err     <= 1'b0;
            disp_data   <= CELL_WATER;
            boat_cnt    <= '0;
        end else begin
            mem_ready   <= accept;
            mem_rd_data <= rd_d;
            mem_err     <= accept && !req_in_range;
            disp_data   <= disp_cell;
            boat_cnt    <= cnt_d;
        end
    end

    assign all_sunk = (boat_cnt == '0) && !busy;

endmodule

// File: tb/tb_board_mem.sv
// Self-checking bench for board_mem against a cell-array reference model.
module tb_board_mem;

    localparam int W = 6;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] mem_addr_x, mem_addr_y, disp_x, disp_y;
    logic [1:0] mem_wr_data, mem_rd_data, disp_data;
    logic       mem_wr_en, mem_in_valid, mem_ready, mem_err, clr_start, busy, all_sunk;
    logic [5:0] boat_cnt;

    board_mem dut (
        .clk          (clk),
        .rstn         (rstn),
        .mem_addr_x   (mem_addr_x),
        .mem_addr_y   (mem_addr_y),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_in_valid (mem_in_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err),
        .clr_start    (clr_start),
        .busy         (busy),
        .disp_x       (disp_x),
        .disp_y       (disp_y),
        .disp_data    (disp_data),
        .boat_cnt     (boat_cnt),
        .all_sunk     (all_sunk)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         model [W*W];
    logic [1:0] last_rd = 2'b00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_boats();
        int n = 0;
        for (int i = 0; i < W*W; i++) if (model[i] == 1) n++;
        return n;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < W*W; i++) model[i] = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted request; every output is predicted from the model before the write lands.
    task automatic do_req(input int x, input int y, input bit we, input logic [1:0] wd,
                          input int dx, input int dy);
        logic [1:0] exp_rd, exp_disp;
        bit         inr;
        mem_addr_x   = 3'(x);
        mem_addr_y   = 3'(y);
        mem_wr_en    = we;
        mem_wr_data  = wd;
        mem_in_valid = 1'b1;
        clr_start    = 1'b0;
        disp_x       = 3'(dx);
        disp_y       = 3'(dy);
        inr      = (x < W) && (y < W);
        exp_rd   = inr ? 2'(model[y*W + x]) : 2'b00;
        exp_disp = (dx < W && dy < W) ? 2'(model[dy*W + dx]) : 2'b00;
        if (inr && we) model[y*W + x] = int'(wd);
        tick();
        check("ready", 8'(mem_ready), 8'd1);
        check("rd_data", 8'(mem_rd_data), 8'(exp_rd));
        check("err", 8'(mem_err), 8'(!inr));
        check("disp", 8'(disp_data), 8'(exp_disp));
        check("boat_cnt", 8'(boat_cnt), 8'(model_boats()));
        check("all_sunk", 8'(all_sunk), 8'(model_boats() == 0));
        last_rd = exp_rd;
    endtask

    task automatic idle_cycle();
        mem_in_valid = 1'b0;
        tick();
        check("idle_ready", 8'(mem_ready), 8'd0);
        check("idle_hold", 8'(mem_rd_data), 8'(last_rd));
        check("idle_err", 8'(mem_err), 8'd0);
    endtask

    // Counts sample points with busy high, starting from the current one.
    task automatic count_busy(output int n, output bit saw_ready, output bit saw_disp);
        n = 0;
        saw_ready = 1'b0;
        saw_disp = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (mem_ready !== 1'b0) saw_ready = 1'b1;
            if (n > 1 && disp_data !== 2'b00) saw_disp = 1'b1;
            tick();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 8'(mem_ready), 8'd0);
        check({tag, "_rd"}, 8'(mem_rd_data), 8'd0);
        check({tag, "_err"}, 8'(mem_err), 8'd0);
        check({tag, "_disp"}, 8'(disp_data), 8'd0);
        check({tag, "_cnt"}, 8'(boat_cnt), 8'd0);
        check({tag, "_busy"}, 8'(busy), 8'd1);
    endtask

    initial begin
        int  n;
        bit  sr, sd;
        rstn = 1'b0;
        mem_addr_x = 3'd0; mem_addr_y = 3'd0; mem_wr_data = 2'b00; mem_wr_en = 1'b0;
        mem_in_valid = 1'b1; clr_start = 1'b0; disp_x = 3'd0; disp_y = 3'd0;
        model_clear();
        #3;
        check_reset_vals("rst");
        tick();
        tick();
        rstn = 1'b1;

        count_busy(n, sr, sd);
        check("busy_len_rst", 8'(n), 8'd36);
        check("busy_no_ready", 8'(sr), 8'd0);
        check("busy_disp_zero", 8'(sd), 8'd0);
        do_req(0, 0, 1'b0, 2'b00, 0, 0);

        do_req(1, 1, 1'b1, 2'b01, 0, 0);
        do_req(2, 1, 1'b1, 2'b01, 1, 1);
        do_req(1, 2, 1'b1, 2'b01, 2, 1);
        do_req(2, 1, 1'b0, 2'b00, 1, 2);
        check("cnt_three", 8'(boat_cnt), 8'd3);
        do_req(1, 1, 1'b1, 2'b10, 1, 2);
        do_req(1, 1, 1'b1, 2'b10, 1, 1);
        check("cnt_two", 8'(boat_cnt), 8'd2);
        do_req(6, 2, 1'b1, 2'b01, 6, 2);
        do_req(2, 7, 1'b1, 2'b01, 1, 2);
        idle_cycle();

        for (int i = 0; i < 150; i++) begin
            logic [1:0] wd;
            wd = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom);
            do_req($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), wd,
                   $urandom_range(0, 7), $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        // Make sure there are boats so the clear visibly drops the count.
        do_req(3, 3, 1'b1, 2'b01, 3, 3);
        mem_addr_x = 3'd0; mem_addr_y = 3'd0; mem_wr_en = 1'b1; mem_wr_data = 2'b01;
        mem_in_valid = 1'b1; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("clr_no_accept", 8'(mem_ready), 8'd0);
        check("clr_cnt", 8'(boat_cnt), 8'd0);
        check("clr_busy", 8'(busy), 8'd1);
        count_busy(n, sr, sd);
        check("busy_len_clr", 8'(n), 8'd36);
        check("clr_no_ready", 8'(sr), 8'd0);
        model_clear();
        do_req(0, 0, 1'b1, 2'b01, 0, 0);
        do_req(1, 2, 1'b1, 2'b01, 0, 0);
        do_req(4, 4, 1'b0, 2'b00, 1, 2);
        check("disp_boat", 8'(disp_data), 8'd1);

        // Restart during clear: the 36-cycle window begins again.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        count_busy(n, sr, sd);
        check("busy_len_restart", 8'(n), 8'd36);
        model_clear();
        do_req(5, 5, 1'b1, 2'b01, 0, 0);

        // Reset asserted mid-clear.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rstn = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        rstn = 1'b1;
        count_busy(n, sr, sd);
        check("busy_len_midrst", 8'(n), 8'd36);
        model_clear();
        do_req(5, 5, 1'b0, 2'b00, 5, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_mem.md
Name: board_mem

Overview:
- Responder end of the board-memory request interface that the bfs block and the game controller drive.
- Holds the WIDTH x WIDTH grid of 2-bit cells and answers each accepted request one cycle later, with read-before-write semantics.
- Runs its own clear engine after reset and on command.
- Maintains a live count of intact boat cells.
- Provides a registered read port for the display path.

Parameters:
- WIDTH, 6, board edge length in cells.
- AW, 3, coordinate width; must satisfy 2**AW >= WIDTH.
- CW, 6, boat counter width; must satisfy 2**CW > WIDTH*WIDTH.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock, asynchronous, active-low.
- mem_addr_x  in  AW  request column.
- mem_addr_y  in  AW  request row.
- mem_wr_data  in  2  write data.
- mem_wr_en  in  1  request is a write.
- mem_in_valid  in  1  request valid.
- mem_rd_data  out  2  old cell contents for the accepted request.
- mem_ready  out  1  response strobe, one cycle after acceptance.
- mem_err  out  1  pulses with mem_ready when the address was out of range.
- clr_start  in  1  starts a full-board clear.
- busy  out  1  clear engine active.
- disp_x  in  AW  display column.
- disp_y  in  AW  display row.
- disp_data  out  2  display cell contents.
- boat_cnt  out  CW  number of cells currently holding 01.
- all_sunk  out  1  high when boat_cnt==0 and busy==0.

Behaviour:
- Cell encoding: 00 water, 01 boat, 10 hit, 11 miss.
- Address mapping: index = y*WIDTH + x.
- Storage is a plain register/RAM array without reset.
- Reset values: mem_ready=0, mem_rd_data=00, mem_err=0, disp_data=00, boat_cnt=0, busy=1, clear index=0.
- FSM states:
  - CLEAR: entered on reset release or on clr_start. Writes 00 to index 0..WIDTH*WIDTH-1, one cell per cycle, so busy lasts exactly WIDTH*WIDTH cycles (36 at default). Forces boat_cnt to 0 on entry. Moves to IDLE after the last index.
  - IDLE: accepts requests.
- Acceptance: a request is accepted on any posedge with mem_in_valid=1, state IDLE and clr_start=0.
  - Next cycle: mem_ready=1 and mem_rd_data = the cell value before this request's write.
  - Holding valid high gives back-to-back transactions, one per cycle, each answered in the following cycle.
  - When no request is accepted, mem_ready=0 and mem_rd_data holds its last value.
- Not accepted while busy: mem_ready stays 0, and the initiator holds valid until ready.
- Write on acceptance: when mem_wr_en=1 the cell is written in the same edge.
- Out of range (x>=WIDTH or y>=WIDTH):
  - Accepted anyway; mem_rd_data=00 and mem_err=1 with mem_ready.
  - No write; boat_cnt unchanged.
- boat_cnt update on accepted in-range writes:
  - +1 when old!=01 and new==01.
  - -1 when old==01 and new!=01.
  - Otherwise unchanged.
  - Saturates at 0 and at WIDTH*WIDTH; it never wraps.
- clr_start priority:
  - Has priority over a same-cycle request; that request is not accepted.
  - During CLEAR, it restarts the index from 0.
- Display port: disp_data is registered with one-cycle latency.
  - Returns 00 while busy or when out of range.
  - Reflects a same-edge request write one cycle later; no bypass.
- Reset mid-operation: everything returns to reset values immediately, and a full clear runs after release.

Decomposition:
- Shared package board_pkg holds:
  - Cell constants CELL_WATER=2'b00, CELL_BOAT=2'b01, CELL_HIT=2'b10, CELL_MISS=2'b11.
  - Default WIDTH.
- Sub-module board_clear_seq: the index counter and busy FSM, with outputs clr_we, clr_idx, busy.
- Counter, response register and array stay in board_mem.

Test Plan:
- Reset release, mem_in_valid held 1 -> busy=1 for 36 cycles; first mem_ready on cycle 38 after release; mem_rd_data=00; boat_cnt=0, all_sunk=1.
- Write 01 to (1,1),(2,1),(1,2), then read (2,1) -> boat_cnt=3, all_sunk=0; read returns 01 with mem_ready one cycle after acceptance.
- Write 10 to (1,1) -> mem_rd_data=01 (old value); boat_cnt=2. Rewrite 10 to (1,1) -> count stays 2.
- Access (6,2) or (2,7) -> mem_ready=1, mem_err=1, mem_rd_data=00; no cell or count change.
- clr_start asserted together with a valid request -> request not accepted, busy 36 cycles, boat_cnt=0; the held request completes after clear with rd_data=00.
- disp_x=1, disp_y=2 with (1,2)=01 -> disp_data=01 one cycle later; rstn pulsed low mid-clear -> all outputs at reset values, clear restarts.
